// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle width, atan table, gain constant and
// FSM state encoding used by the iterative and future pipelined variants.
package cordic_pkg;

   localparam int ANG_W = 32;
   localparam int TAB_N = 30;

   // K for a long iteration count, Q16 (1.646760)
   localparam logic [31:0] CORDIC_GAIN = 32'h0001_A592;

   typedef enum logic [1:0] {
      IDLE,
      ROTATE,
      DONE
   } state_t;

   // round(atan(2^-i) * 2^32 / 360), 0x20000000 = 45 deg
   localparam logic [31:0] ATAN_TAB [TAB_N] = '{
      32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
      32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
      32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
      32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
      32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
      32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
      32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
      32'h0000_0003, 32'h0000_0001
   };

endpackage

// File: rtl/cordic_atan2_if.sv
// Valid/ready bundle for cordic_atan2: (x, y) request in, angle/mag out.
// slave = the CORDIC block, master = producer/consumer driving it.
interface cordic_atan2_if #(
   parameter int XY_W  = 16,
   parameter int ANG_W = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [XY_W-1:0]  x_in;
   logic signed [XY_W-1:0]  y_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [ANG_W-1:0]        angle_out;
   logic [XY_W+1:0]         mag_out;

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, angle_out, mag_out
   );

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, angle_out, mag_out
   );
endinterface

// File: rtl/cordic_microrot.sv
// One combinational vectoring micro-rotation: drives y towards zero.
// Ports: x/y/z current vector and angle, i shift index, a = atan_tab[i];
// x_n/y_n/z_n next values (all computed from the pre-update x/y).
module cordic_microrot #(
   parameter int W  = 18,
   parameter int AW = 32
) (
   input  logic signed [W-1:0]  x,
   input  logic signed [W-1:0]  y,
   input  logic [AW-1:0]        z,
   input  logic [4:0]           i,
   input  logic [AW-1:0]        a,
   output logic signed [W-1:0]  x_n,
   output logic signed [W-1:0]  y_n,
   output logic [AW-1:0]        z_n
);
   logic signed [W-1:0] xs;
   logic signed [W-1:0] ys;

   assign xs = x >>> i;
   assign ys = y >>> i;

   always_comb begin
      x_n = x;
      y_n = y;
      z_n = z;
      if (!y[W-1]) begin
         x_n = x + ys;
         y_n = y - xs;
         z_n = z + a;
      end else begin
         x_n = x - ys;
         y_n = y + xs;
         z_n = z - a;
      end
   end
endmodule

// File: rtl/cordic_atan2.sv
// Iterative vectoring CORDIC: (x, y) -> binary angle and K-scaled magnitude.
// Ports: clk, rst (sync, active high), bus (slave: in_valid/in_ready,
// x_in, y_in, out_valid/out_ready, angle_out, mag_out).
module cordic_atan2
   import cordic_pkg::*;
#(
   parameter int XY_W = 16,
   parameter int ITER = 16
) (
   input  logic           clk,
   input  logic           rst,
   cordic_atan2_if.slave  bus
);
   localparam int W = XY_W + 2;

   state_t              state;
   logic signed [W-1:0] x_q;
   logic signed [W-1:0] y_q;
   logic [ANG_W-1:0]    z_q;
   logic signed [W-1:0] x_n;
   logic signed [W-1:0] y_n;
   logic [ANG_W-1:0]    z_n;
   logic signed [W-1:0] x_ext;
   logic signed [W-1:0] y_ext;
   logic [4:0]          cnt;
   logic                zero_q;
   logic                ov_q;
   logic [ANG_W-1:0]    ang_q;
   logic [W-1:0]        mag_q;
   logic                last;

   assign x_ext = {{(W-XY_W){bus.x_in[XY_W-1]}}, bus.x_in};
   assign y_ext = {{(W-XY_W){bus.y_in[XY_W-1]}}, bus.y_in};
   assign last  = (cnt == 5'(ITER - 1));

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = ov_q;
   assign bus.angle_out = ang_q;
   assign bus.mag_out   = mag_q;

   cordic_microrot #(
      .W  (W),
      .AW (ANG_W)
   ) u_rot (
      .x   (x_q),
      .y   (y_q),
      .z   (z_q),
      .i   (cnt),
      .a   (ATAN_TAB[cnt]),
      .x_n (x_n),
      .y_n (y_n),
      .z_n (z_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         cnt    <= '0;
         zero_q <= 1'b0;
         ov_q   <= 1'b0;
         ang_q  <= '0;
         mag_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // left half-plane: rotate by 180 deg so x starts >= 0
                  if (bus.x_in[XY_W-1]) begin
                     x_q <= -x_ext;
                     y_q <= -y_ext;
                     z_q <= {1'b1, {(ANG_W-1){1'b0}}};
                  end else begin
                     x_q <= x_ext;
                     y_q <= y_ext;
                     z_q <= '0;
                  end
                  zero_q <= (bus.x_in == '0) && (bus.y_in == '0);
                  cnt    <= '0;
                  state  <= ROTATE;
               end
            end
            ROTATE: begin
               x_q <= x_n;
               y_q <= y_n;
               z_q <= z_n;
               cnt <= cnt + 5'd1;
               if (last) begin
                  state <= DONE;
                  ov_q  <= 1'b1;
                  // z keeps accumulating on (0,0); force a clean result
                  ang_q <= zero_q ? '0 : z_n;
                  mag_q <= zero_q ? '0 : x_n;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  ov_q  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2: angle/magnitude vectors, zero input,
// backpressure and mid-rotation reset.
module tb_cordic_atan2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cordic_atan2_if bus ();

   cordic_atan2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_asrt = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ang(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
      logic [31:0] d;
      logic signed [31:0] sd;
      logic ok;
      d  = obs - exp;
      sd = signed'(d);
      ok = (sd <= 32'sd262144) && (sd >= -32'sd262144);
      n_asrt++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h +-2^18", tag, obs, exp);
      end
   endtask

   task automatic chk_mag(input string tag, input logic [17:0] obs,
                          input int exp);
      int d;
      logic ok;
      d  = int'(obs) - exp;
      ok = (d <= 4) && (d >= -4);
      n_asrt++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +-4", tag, obs, exp);
      end
   endtask

   task automatic send(input logic signed [15:0] x,
                       input logic signed [15:0] y);
      int n;
      n = 0;
      bus.x_in     = x;
      bus.y_in     = y;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic get(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 100);
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("xfer_in_ready", 64'(bus.in_ready), 64'd1);
      chk("xfer_out_valid", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [31:0] a0;
      logic [17:0] m0;
      logic seen;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_angle", 64'(bus.angle_out), 64'd0);
      chk("rst_mag", 64'(bus.mag_out), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

      // 45 deg
      send(16'sd16384, 16'sd16384);
      get(lat);
      chk("lat_45", 64'(lat), 64'd16);
      chk_ang("ang_45", bus.angle_out, 32'h2000_0000);
      chk_mag("mag_45", bus.mag_out, 38155);
      take();

      // 230 deg
      send(-16'sd10531, -16'sd12551);
      get(lat);
      chk_ang("ang_230", bus.angle_out, 32'hA38E_38E3);
      chk_mag("mag_230", bus.mag_out, 26981);
      take();

      // -90 deg
      send(16'sd0, -16'sd16384);
      get(lat);
      chk_ang("ang_m90", bus.angle_out, 32'hC000_0000);
      take();

      // 180 deg, most negative x
      send(-16'sd32768, 16'sd0);
      get(lat);
      chk_ang("ang_180", bus.angle_out, 32'h8000_0000);
      chk_mag("mag_180", bus.mag_out, 53961);
      take();

      // zero input
      send(16'sd0, 16'sd0);
      get(lat);
      chk("lat_zero", 64'(lat), 64'd16);
      chk("ang_zero", 64'(bus.angle_out), 64'd0);
      chk("mag_zero", 64'(bus.mag_out), 64'd0);
      take();

      // backpressure with an ignored second request
      send(16'sd16384, 16'sd16384);
      get(lat);
      a0 = bus.angle_out;
      m0 = bus.mag_out;
      chk_ang("bp_ang", a0, 32'h2000_0000);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            bus.x_in     = 16'sd100;
            bus.y_in     = -16'sd5;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_ang_hold", 64'(bus.angle_out), 64'(a0));
         chk("bp_mag_hold", 64'(bus.mag_out), 64'(m0));
      end
      bus.in_valid = 1'b0;
      take();
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("bp_no_ghost", 64'(seen), 64'd0);

      // reset during iteration 7 of a 60 deg request
      @(negedge clk);
      send(16'sd8192, 16'sd14189);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_mid_idle", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("rst_discard", 64'(seen), 64'd0);

      @(negedge clk);
      send(16'sd8192, 16'sd14189);
      get(lat);
      chk("lat_60", 64'(lat), 64'd16);
      chk_ang("ang_60", bus.angle_out, 32'h2AAA_AAAA);
      take();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
